// File: rtl/resp_misr.sv
// resp_misr: compacts a stream of 3-bit responses {o1,o2,o3} into a MISR
// signature and, after a programmed number of vectors, compares it against a
// golden value so that a whole test run reduces to a single pass/fail bit.
//
// Ports:
//   clk, rst            : single clock, asynchronous active-high reset
//   start               : one-cycle pulse; samples num_vec and exp_sig
//   num_vec, exp_sig    : run length and golden signature
//   in_valid, o1/o2/o3  : response handshake (accepted when in_ready is high)
//   in_ready, busy      : high while a run is collecting responses
//   done, pass, timeout : run finished / signature matched / watchdog fired
//   sig, count          : current signature and responses accepted this run
//
// Optional build macro RESP_MISR_TIMEOUT_EN adds an idle watchdog that ends a
// run after TIMEOUT consecutive RUN cycles without an accept. Without it,
// timeout is tied low and a run waits indefinitely for responses.
module resp_misr #(
    parameter int               SIG_W   = 16,
    parameter int               CNT_W   = 8,
    parameter logic [SIG_W-1:0] POLY    = 16'h1021,
    parameter logic [SIG_W-1:0] SEED    = 16'hFFFF,
    parameter int               TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [SIG_W-1:0] exp_sig,
    input  logic             in_valid,
    input  logic             o1,
    input  logic             o2,
    input  logic             o3,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [SIG_W-1:0] exp_q, exp_d;
    logic             timeout_q, timeout_d;

    // Next MISR value if the current response is folded in.
    logic [SIG_W-1:0] sig_step;
    always_comb begin
        sig_step = {sig_q[SIG_W-2:0], 1'b0}
                 ^ (sig_q[SIG_W-1] ? POLY : '0)
                 ^ {{(SIG_W-3){1'b0}}, o1, o2, o3};
    end

`ifdef RESP_MISR_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sig_q     <= SEED;
            count_q   <= '0;
            num_q     <= '0;
            exp_q     <= '0;
            timeout_q <= 1'b0;
`ifdef RESP_MISR_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            count_q   <= count_d;
            num_q     <= num_d;
            exp_q     <= exp_d;
            timeout_q <= timeout_d;
`ifdef RESP_MISR_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        count_d   = count_q;
        num_d     = num_q;
        exp_d     = exp_q;
        timeout_d = timeout_q;
`ifdef RESP_MISR_TIMEOUT_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            // A start from DONE behaves exactly like one from IDLE.
            IDLE, DONE: begin
                if (start) begin
                    sig_d     = SEED;
                    count_d   = '0;
                    num_d     = num_vec;
                    exp_d     = exp_sig;
                    timeout_d = 1'b0;
`ifdef RESP_MISR_TIMEOUT_EN
                    wd_d      = '0;
`endif
                    state_d   = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // in_ready is high throughout RUN, so in_valid alone is an accept.
                if (in_valid) begin
                    sig_d   = sig_step;
                    count_d = count_q + 1'b1;
`ifdef RESP_MISR_TIMEOUT_EN
                    wd_d    = '0;
`endif
                    if (count_d == num_q) begin
                        state_d = DONE;
                    end
                end
`ifdef RESP_MISR_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // This idle cycle is the TIMEOUT-th in a row.
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign pass     = done && !timeout_q && (sig_q == exp_q);
    assign timeout  = timeout_q;
    assign sig      = sig_q;
    assign count    = count_q;

endmodule

// File: tb/tb_resp_misr.sv
module tb_resp_misr;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_vec;
    logic [15:0] exp_sig;
    logic        in_valid;
    logic        o1, o2, o3;
    logic        in_ready, busy, done, pass, timeout;
    logic [15:0] sig;
    logic [7:0]  count;

    resp_misr dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .exp_sig(exp_sig),
        .in_valid(in_valid), .o1(o1), .o2(o2), .o3(o3),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .sig(sig), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [2:0] v);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'd0, v};
    endfunction

    function automatic logic [15:0] sb_pop();
        if (sb_q.size() == 0) return 16'hxxxx;
        return sb_q.pop_front();
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [15:0] exp_sig;
        logic [15:0] want_sig;
        logic        want_pass;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [2:0]  vecs[8];
        logic [15:0] m;
        logic [15:0] want;
        int idx, cyc;
        bit mid;
        bit acc;

        // Single-vector runs from SEED: sig = 16'hEFDF ^ v.
        tbl[0] = '{3'b101, 16'hEFDA, 16'hEFDA, 1'b1};
        tbl[1] = '{3'b101, 16'h0000, 16'hEFDA, 1'b0};
        tbl[2] = '{3'b000, 16'hEFDF, 16'hEFDF, 1'b1};
        tbl[3] = '{3'b111, 16'hEFD8, 16'hEFD8, 1'b1};
        tbl[4] = '{3'b011, 16'hEFDD, 16'hEFDC, 1'b0};
        tbl[5] = '{3'b010, 16'hEFDD, 16'hEFDD, 1'b1};
        tbl[6] = '{3'b110, 16'hFFFF, 16'hEFD9, 1'b0};
        tbl[7] = '{3'b001, 16'hEFDE, 16'hEFDE, 1'b1};

        rst = 1'b1; start = 1'b0; num_vec = '0; exp_sig = '0;
        in_valid = 1'b0; {o1, o2, o3} = 3'b000;
        #12;
        chk("reset_sig", sig, 16'hFFFF);
        chk("reset_count", count, 0);
        chk("reset_flags", {in_ready, busy, done, pass, timeout}, 5'b00000);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_flags", {in_ready, busy, done}, 3'b000);

        // Table-driven single-vector runs.
        for (int i = 0; i < 8; i++) begin
            start = 1'b1; num_vec = 8'd1; exp_sig = tbl[i].exp_sig;
            sb_q.push_back(tbl[i].want_sig);
            tick();
            start = 1'b0;
            chk($sformatf("t%0d_ready", i), {in_ready, busy, done}, 3'b110);
            in_valid = 1'b1; {o1, o2, o3} = tbl[i].v;
            tick();
            in_valid = 1'b0;
            chk($sformatf("t%0d_sig", i), sig, sb_pop());
            chk($sformatf("t%0d_pass", i), pass, tbl[i].want_pass);
            chk($sformatf("t%0d_done", i), {done, in_ready, busy}, 3'b100);
            chk($sformatf("t%0d_count", i), count, 1);
        end

        // Zero-vector run completes straight away.
        start = 1'b1; num_vec = 8'd0; exp_sig = 16'hFFFF;
        sb_q.push_back(16'hFFFF);
        tick();
        start = 1'b0;
        chk("zero_done", {done, in_ready}, 2'b10);
        chk("zero_pass", pass, 1);
        chk("zero_count", count, 0);
        chk("zero_sig", sig, sb_pop());

        // Eight vectors with random gaps, garbage on idle cycles, mid-run start.
        m = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            vecs[i] = 3'($urandom_range(0, 7));
            m = model_step(m, vecs[i]);
        end
        sb_q.push_back(m);
        start = 1'b1; num_vec = 8'd8; exp_sig = m;
        tick();
        start = 1'b0;
        idx = 0; cyc = 0; mid = 0;
        while (!done && cyc < 300) begin
            in_valid = ($urandom_range(0, 2) != 0);
            {o1, o2, o3} = in_valid ? vecs[idx < 8 ? idx : 0] : 3'($urandom_range(0, 7));
            if (idx == 3 && !mid) begin
                start = 1'b1; num_vec = 8'd3; exp_sig = 16'h0000; mid = 1;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            start = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        want = sb_pop();
        chk("gap_done", done, 1);
        chk("gap_accepts", idx, 8);
        chk("gap_count", count, 8);
        chk("gap_sig", sig, want);
        chk("gap_pass", pass, 1);

        // DONE holds while responses keep arriving.
        in_valid = 1'b1; {o1, o2, o3} = 3'b111;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("hold_sig", sig, want);
        chk("hold_state", {done, count}, {1'b1, 8'd8});

        // Asynchronous reset in the middle of a run.
        start = 1'b1; num_vec = 8'd5; exp_sig = 16'h1234;
        tick();
        start = 1'b0;
        in_valid = 1'b1; {o1, o2, o3} = 3'b011;
        tick();
        tick();
        in_valid = 1'b0;
        chk("pre_rst_count", count, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_sig", sig, 16'hFFFF);
        chk("arst_count", count, 0);
        chk("arst_flags", {in_ready, busy, done, pass, timeout}, 5'b00000);
        tick();
        rst = 1'b0;
        tick();

`ifdef RESP_MISR_TIMEOUT_EN
        start = 1'b1; num_vec = 8'd4; exp_sig = 16'h0000;
        tick();
        start = 1'b0;
        in_valid = 1'b1; {o1, o2, o3} = 3'b100;
        tick();
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        chk("to_not_yet", done, 0);
        tick();
        chk("to_flags", {done, timeout, pass}, 3'b110);
        chk("to_count", count, 2);
        start = 1'b1; num_vec = 8'd0; exp_sig = 16'hFFFF;
        tick();
        start = 1'b0;
        chk("to_clear", {timeout, pass}, 2'b01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
